// File: rtl/sweeper_pkg.sv
// sweeper_pkg: shared state encoding, MODE gate codes and parameter limits for truth_table_sweeper
package sweeper_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
  localparam int MODE_AND  = 0;
  localparam int MODE_OR   = 1;
  localparam int MODE_XOR  = 2;
  localparam int MODE_NAND = 3;
  localparam int MODE_NOR  = 4;
  localparam int N_IN_MAX  = 8;
  localparam int DWELL_MIN = 2;
  localparam int DWELL_MAX = 1023;
endpackage

// File: rtl/truth_ref_gate.sv
// truth_ref_gate: combinational reference gate giving the expected output for a row (dut_in -> expected)
module truth_ref_gate
  import sweeper_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int MODE = MODE_OR
) (
  input  logic [N_IN-1:0] dut_in,
  output logic            expected
);
  always_comb
    expected = (MODE == MODE_AND)  ?  (&dut_in) :
               (MODE == MODE_OR)   ?  (|dut_in) :
               (MODE == MODE_XOR)  ?  (^dut_in) :
               (MODE == MODE_NAND) ? ~(&dut_in) : ~(|dut_in);
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input row to a gate under test, holds it DWELL cycles, checks dut_out against MODE
// Ports: clk, reset (sync, active high), start, dut_out in; dut_in, sample_strobe, busy, done, pass, err_count out.
// Optional SWEEPER_FIRST_FAIL_EN adds first_fail_row / first_fail_vld recording the first mismatching row of a sweep.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int DWELL = 50,
  parameter int MODE  = MODE_OR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] dut_in,
  output logic            sample_strobe,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count
`ifdef SWEEPER_FIRST_FAIL_EN
  ,
  output logic [N_IN-1:0] first_fail_row,
  output logic            first_fail_vld
`endif
);
  localparam int CW = $clog2(DWELL);
  if (N_IN < 1 || N_IN > N_IN_MAX || DWELL < DWELL_MIN || DWELL > DWELL_MAX || MODE < MODE_AND || MODE > MODE_NOR)
    $error("truth_table_sweeper: illegal parameter N_IN=%0d DWELL=%0d MODE=%0d", N_IN, DWELL, MODE);
  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            expected, accept, mismatch;
  truth_ref_gate #(.N_IN(N_IN), .MODE(MODE)) u_ref (.dut_in(dut_in), .expected(expected));
  assign accept        = start && state != APPLY;
  assign sample_strobe = state == APPLY && cnt == CW'(DWELL - 1);
  assign mismatch      = sample_strobe && dut_out != expected;
  assign busy          = state == APPLY;
  assign done          = state == DONE;
  assign pass          = done && err_count == '0;
  always_comb
    state_nx = accept ? APPLY : (sample_strobe && &dut_in) ? DONE : state;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  // dut_in wraps from the last row back to 0 on the final strobe, so DONE sees dut_in=0 for free
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      dut_in    <= '0;
      cnt       <= '0;
      err_count <= '0;
    end else if (state == APPLY) begin
      cnt       <= sample_strobe ? '0 : cnt + CW'(1);
      dut_in    <= sample_strobe ? dut_in + N_IN'(1) : dut_in;
      err_count <= err_count + (N_IN + 1)'(mismatch);
    end
  end
`ifdef SWEEPER_FIRST_FAIL_EN
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      first_fail_row <= '0;
      first_fail_vld <= 1'b0;
    end else if (mismatch && !first_fail_vld) begin
      first_fail_row <= dut_in;
      first_fail_vld <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed self-checking bench for truth_table_sweeper in three configurations
module tb_truth_table_sweeper;
  logic clk = 1'b0, reset = 1'b1;
  logic st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
  logic fault0 = 1'b0;
  logic dout0, dout1, dout2;
  logic [1:0] din0, din2;
  logic [2:0] din1;
  logic stb0, stb1, stb2, busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
  logic [2:0] err0, err2;
  logic [3:0] err1;
`ifdef SWEEPER_FIRST_FAIL_EN
  logic [1:0] ffr0, ffr2;
  logic [2:0] ffr1;
  logic ffv0, ffv1, ffv2;
`endif
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  assign dout0 = fault0 ? 1'b0 : |din0;
  assign dout1 = ~^din1;
  assign dout2 = stb2 ? |din2 : ~|din2;
  truth_table_sweeper #(.N_IN(2), .DWELL(4), .MODE(1)) u0 (
    .clk(clk), .reset(reset), .start(st0), .dut_out(dout0), .dut_in(din0), .sample_strobe(stb0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
`ifdef SWEEPER_FIRST_FAIL_EN
    , .first_fail_row(ffr0), .first_fail_vld(ffv0)
`endif
  );
  truth_table_sweeper #(.N_IN(3), .DWELL(4), .MODE(2)) u1 (
    .clk(clk), .reset(reset), .start(st1), .dut_out(dout1), .dut_in(din1), .sample_strobe(stb1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef SWEEPER_FIRST_FAIL_EN
    , .first_fail_row(ffr1), .first_fail_vld(ffv1)
`endif
  );
  truth_table_sweeper #(.N_IN(2), .DWELL(2), .MODE(1)) u2 (
    .clk(clk), .reset(reset), .start(st2), .dut_out(dout2), .dut_in(din2), .sample_strobe(stb2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
`ifdef SWEEPER_FIRST_FAIL_EN
    , .first_fail_row(ffr2), .first_fail_vld(ffv2)
`endif
  );
  typedef struct {
    int cyc;
    logic [1:0] din;
    logic busy, done, stb;
  } vec_t;
  vec_t tbl[10];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic pulse0();
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
  endtask
  task automatic run0(input int n0, output int n);
    n = n0;
    while (!done0 && n < 200) begin
      tick();
      n++;
    end
  endtask
  task automatic chk_idle0(input string nm);
    chk({nm, ".din"}, din0, 0);
    chk({nm, ".stb"}, stb0, 0);
    chk({nm, ".busy"}, busy0, 0);
    chk({nm, ".done"}, done0, 0);
    chk({nm, ".pass"}, pass0, 0);
    chk({nm, ".err"}, err0, 0);
  endtask
  initial begin
    int cur, n, ns;
    tbl[0] = '{1, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{3, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{4, 2'd0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{5, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8, 2'd1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{9, 2'd2, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{13, 2'd3, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{16, 2'd3, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{17, 2'd0, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{21, 2'd0, 1'b0, 1'b1, 1'b0};
    tick();
    tick();
    reset = 1'b0;
    chk_idle0("reset");
    // ideal OR sweep checked cycle by cycle against the table
    pulse0();
    cur = 1;
    for (int i = 0; i < 10; i++) begin
      while (cur < tbl[i].cyc) begin
        tick();
        cur++;
      end
      chk($sformatf("tbl%0d.din", i), din0, tbl[i].din);
      chk($sformatf("tbl%0d.busy", i), busy0, tbl[i].busy);
      chk($sformatf("tbl%0d.done", i), done0, tbl[i].done);
      chk($sformatf("tbl%0d.stb", i), stb0, tbl[i].stb);
    end
    chk("ideal.err", err0, 0);
    chk("ideal.pass", pass0, 1);
    // stuck-at-0 gate: rows 1,2,3 mismatch
    fault0 = 1'b1;
    pulse0();
    chk("stuck.restart_done", done0, 0);
    run0(1, n);
    chk("stuck.latency", n, 17);
    chk("stuck.err", err0, 3);
    chk("stuck.pass", pass0, 0);
`ifdef SWEEPER_FIRST_FAIL_EN
    chk("stuck.ffr", ffr0, 1);
    chk("stuck.ffv", ffv0, 1);
`endif
    // inverted XOR on 3-input XOR checker: every row mismatches
    st1 = 1'b1;
    tick();
    st1 = 1'b0;
    n = 1;
    while (!done1 && n < 200) begin
      tick();
      n++;
    end
    chk("xor3.latency", n, 33);
    chk("xor3.err", err1, 8);
    chk("xor3.pass", pass1, 0);
    chk("xor3.din", din1, 0);
    // DWELL=2, dut_out wrong in every non-strobe cycle
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    n = 1;
    ns = 0;
    while (!done2 && n < 200) begin
      ns += int'(stb2);
      tick();
      n++;
    end
    chk("dw2.latency", n, 9);
    chk("dw2.strobes", ns, 4);
    chk("dw2.err", err2, 0);
    chk("dw2.pass", pass2, 1);
    // reset in the row-2 strobe cycle aborts without counting
    pulse0();
    n = 1;
    while (!(din0 == 2'd2 && stb0) && n < 200) begin
      tick();
      n++;
    end
    chk("abort.reach_row2", n, 12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle0("abort");
`ifdef SWEEPER_FIRST_FAIL_EN
    chk("abort.ffv", ffv0, 0);
`endif
    fault0 = 1'b0;
    pulse0();
    run0(1, n);
    chk("post_abort.latency", n, 17);
    chk("post_abort.err", err0, 0);
    chk("post_abort.pass", pass0, 1);
    // start mid-sweep is ignored; start after done restarts cleanly
    fault0 = 1'b1;
    pulse0();
    repeat (4) tick();
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    chk("midstart.busy", busy0, 1);
    chk("midstart.din", din0, 1);
    run0(6, n);
    chk("midstart.latency", n, 17);
    chk("midstart.err", err0, 3);
    repeat (3) tick();
    chk("hold.done", done0, 1);
    chk("hold.err", err0, 3);
    pulse0();
    chk("restart.done", done0, 0);
    chk("restart.err", err0, 0);
    chk("restart.busy", busy0, 1);
    chk("restart.din", din0, 0);
    run0(1, n);
    chk("restart.latency", n, 17);
    chk("restart.err_end", err0, 3);
    // reset wins over start at the same edge
    reset = 1'b1;
    st0 = 1'b1;
    tick();
    reset = 1'b0;
    st0 = 1'b0;
    chk_idle0("rst_prio");
    tick();
    chk("rst_prio.stay_idle", busy0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter N_IN, default 2, number of gate-under-test inputs; legal range 1..8.
REQ-002 Parameter DWELL, default 50, clock cycles each truth-table row is held; legal range 2..1023.
REQ-003 Parameter MODE, default 1, expected gate function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a full sweep; sampled only in IDLE or DONE.
REQ-007 dut_out  input  1  output of the gate under test.
REQ-008 dut_in  output  N_IN  row pattern driven to the gate-under-test inputs; bit N_IN-1 is input A (MSB).
REQ-009 sample_strobe  output  1  one-cycle pulse in the cycle dut_out is compared.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  high from sweep completion until the next accepted start.
REQ-012 pass  output  1  valid while done is high; 1 when err_count equals 0.
REQ-013 err_count  output  N_IN+1  number of mismatching rows in the current or last sweep.

Function
REQ-014 States: IDLE, APPLY, DONE; IDLE->APPLY and DONE->APPLY on start; APPLY->DONE after the final row is sampled.
REQ-015 Accepting start at edge t: busy=1, dut_in=0, err_count=0, done=0, pass=0 from cycle t+1.
REQ-016 Rows are applied in ascending binary order 0..2^N_IN-1, each held for exactly DWELL cycles.
REQ-017 Dwell counter runs 0..DWELL-1. At count DWELL-1: sample_strobe=1, dut_out is compared against MODE applied to dut_in, and err_count increments on mismatch.
REQ-018 dut_in advances to the next row in the cycle after the strobe; no idle gap between rows.
REQ-019 After the strobe of row 2^N_IN-1, the next cycle enters DONE: done=1, busy=0, dut_in=0, and pass=(err_count==0). done therefore rises at cycle t+1+2^N_IN*DWELL.
REQ-020 err_count cannot overflow, since its maximum value 2^N_IN fits in N_IN+1 bits; no saturation logic is required.
REQ-021 start while busy is ignored; the sweep continues unaffected.
REQ-022 done, pass and err_count hold in DONE until start is accepted or reset is asserted.
REQ-023 dut_out is used only in strobe cycles; its value in all other cycles has no effect.

Reset
REQ-024 Reset values: state=IDLE, dut_in=0, sample_strobe=0, busy=0, done=0, pass=0, err_count=0, dwell counter=0.
REQ-025 Reset asserted mid-sweep aborts the sweep at the next edge with the REQ-024 values, and no strobe occurs in that cycle.
REQ-026 Reset has priority over start when both are high at the same edge.

Configuration
REQ-027 Macro SWEEPER_FIRST_FAIL_EN, when defined, adds output first_fail_row (N_IN) and output first_fail_vld (1).
REQ-028 With SWEEPER_FIRST_FAIL_EN defined: on the first mismatch of a sweep, first_fail_row captures dut_in and first_fail_vld is set; both clear on reset and on an accepted start.
REQ-029 Without SWEEPER_FIRST_FAIL_EN, neither the ports nor the capture registers exist, and all other behaviour is identical.

Structure
REQ-030 Package sweeper_pkg holds the state enum, the MODE encoding constants and the maximum N_IN and DWELL limits.
REQ-031 Sub-module truth_ref_gate (parameters N_IN and MODE) computes the expected output combinationally from dut_in; it is instantiated once.
REQ-032 Illegal parameter values are flagged by an elaboration-time check.

Verification
REQ-033 N_IN=2, DWELL=4, MODE=1, ideal OR DUT, start pulsed -> dut_in steps 0,1,2,3 every 4 cycles; done at start+17; err_count=0; pass=1.
REQ-034 Same configuration, DUT stuck at 0 -> err_count=3, pass=0; with the macro defined, first_fail_row=1 and first_fail_vld=1.
REQ-035 N_IN=3, MODE=2, DUT is an inverted XOR -> err_count=8 (4-bit value 1000), pass=0.
REQ-036 Reset asserted while dut_in=2 -> next cycle all outputs 0 and state is IDLE; a following start produces a clean full sweep.
REQ-037 start re-pulsed mid-sweep and again after done -> the first pulse has no effect; the second clears done and err_count and restarts at row 0.
REQ-038 DWELL=2 with dut_out toggling in non-strobe cycles -> only strobe-cycle values are counted, and the sample_strobe count equals 2^N_IN.
